// File: rtl/li_traffic_checker.sv
// Latency-insensitive ramp source and checking sink that sit on both ends of a wrapped DUT.
// Handles credit, carloni (stop) and qsys (ready) flow control, with LFSR-driven bubbles and stalls.
module li_traffic_checker #(
    parameter int          DATA_WIDTH = 16,
    parameter int          MODE       = 0,
    parameter int          FIFO_ADDR  = 6,
    parameter int          NUM_BEATS  = 200,
    parameter int          BUBBLE_EN  = 1,
    parameter int          STALL_EN   = 1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          TIMEOUT    = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_start,
    output logic [DATA_WIDTH-1:0] o_src_data,
    output logic                  o_src_data_valid,
    output logic                  o_src_valid,
    input  logic                  i_src_feedback,
    input  logic [DATA_WIDTH-1:0] i_snk_data,
    input  logic                  i_snk_data_valid,
    input  logic                  i_snk_valid,
    output logic                  o_snk_feedback,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_timeout,
    output logic [15:0]           o_err_count,
    output logic [15:0]           o_first_err_idx
);

    // Handshake: a beat moves when valid=1 and the link allows it -- credit: every valid beat
    // moves and costs a credit, feedback=1 returns one; carloni: moves when feedback(stop)=0;
    // qsys: moves when feedback(ready)=1. A non-moving carloni/qsys beat is held unchanged.
    localparam int             CRW        = FIFO_ADDR + 1;
    localparam logic [CRW-1:0] N_CREDITS  = CRW'(2 ** FIFO_ADDR);
    localparam logic [CRW-1:0] ONE_C      = CRW'(1);
    localparam logic [31:0]    BEATS      = 32'(NUM_BEATS);
    localparam logic [31:0]    TMO        = 32'(TIMEOUT);
    localparam bit             IS_CREDIT  = (MODE == 0);
    localparam bit             IS_CARLONI = (MODE == 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

    state_t                  state, state_next;
    logic                    start_q, start_edge, clear_run, active, to_timeout, timeout_hit;
    logic [15:0]             lfsr;
    logic                    lfsr_fb, bubble, stall;
    logic [CRW-1:0]          credits, credits_n, pending, pending_n;
    logic [31:0]             src_idx, src_idx_n, idx_tmp, exp_idx, idle_cnt;
    logic                    src_go, send, src_valid_n, src_dv_n;
    logic [DATA_WIDTH-1:0]   src_data_n;
    logic                    snk_ret, snk_accept, chk, mism;

    assign start_edge  = i_start & ~start_q;
    assign active      = (state == S_RUN) || (state == S_WAIT);
    assign clear_run   = start_edge && ((state == S_IDLE) || (state == S_DONE));
    assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign bubble      = (BUBBLE_EN != 0) && lfsr[0];
    assign stall       = (STALL_EN != 0) && lfsr[1] && active;
    assign timeout_hit = idle_cnt >= TMO;

    assign o_busy = active;
    assign o_done = (state == S_DONE);
    assign o_pass = o_done && (o_err_count == 16'd0) && !o_timeout;

    always_comb begin
        state_next = state;
        to_timeout = 1'b0;
        case (state)
            S_IDLE: if (start_edge) state_next = S_RUN;
            S_RUN: begin
                if (timeout_hit) begin
                    state_next = S_DONE;
                    to_timeout = 1'b1;
                end else if (src_idx == BEATS) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (exp_idx == BEATS) begin
                    state_next = S_DONE;
                end else if (timeout_hit) begin
                    state_next = S_DONE;
                    to_timeout = 1'b1;
                end
            end
            S_DONE: if (start_edge) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    // Source: next beat is computed here and registered, so all source outputs are flops.
    always_comb begin
        src_go      = IS_CARLONI ? ~i_src_feedback : i_src_feedback;
        send        = 1'b0;
        idx_tmp     = src_idx;
        src_idx_n   = src_idx;
        src_valid_n = 1'b0;
        src_dv_n    = 1'b0;
        src_data_n  = o_src_data;
        credits_n   = credits;
        if (IS_CREDIT) begin
            send        = (state == S_RUN) && (src_idx < BEATS) && (credits != '0);
            src_valid_n = send;
            src_dv_n    = send && !bubble;
            if (send && !bubble) begin
                src_data_n = src_idx[DATA_WIDTH-1:0];
                src_idx_n  = src_idx + 32'd1;
            end
            if (send && !i_src_feedback) begin
                credits_n = credits - ONE_C;
            end else if (!send && i_src_feedback && (credits != N_CREDITS)) begin
                credits_n = credits + ONE_C;
            end
        end else if (state == S_RUN) begin
            if (o_src_valid && !src_go) begin
                src_valid_n = o_src_valid;
                src_dv_n    = o_src_data_valid;
            end else begin
                if (o_src_valid && o_src_data_valid) idx_tmp = src_idx + 32'd1;
                src_idx_n = idx_tmp;
                if (idx_tmp < BEATS) begin
                    if (bubble) begin
                        src_valid_n = !IS_CARLONI;
                    end else begin
                        src_valid_n = 1'b1;
                        src_dv_n    = 1'b1;
                        src_data_n  = idx_tmp[DATA_WIDTH-1:0];
                    end
                end
            end
        end
    end

    // Sink: credit returns keep flowing outside a run so the link never loses credits.
    always_comb begin
        snk_ret        = 1'b0;
        snk_accept     = 1'b0;
        o_snk_feedback = 1'b0;
        pending_n      = pending;
        if (IS_CREDIT) begin
            snk_ret        = !stall && (pending != '0);
            o_snk_feedback = snk_ret;
            snk_accept     = i_snk_valid;
            if (snk_accept && !snk_ret) begin
                pending_n = pending + ONE_C;
            end else if (!snk_accept && snk_ret) begin
                pending_n = pending - ONE_C;
            end
        end else if (IS_CARLONI) begin
            o_snk_feedback = stall;
            snk_accept     = i_snk_valid && !stall;
        end else begin
            o_snk_feedback = active && !stall;
            snk_accept     = i_snk_valid && active && !stall;
        end
        chk  = snk_accept && i_snk_data_valid && active;
        mism = chk && (i_snk_data != exp_idx[DATA_WIDTH-1:0]);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= S_IDLE;
            start_q          <= 1'b0;
            lfsr             <= LFSR_SEED;
            credits          <= N_CREDITS;
            pending          <= '0;
            src_idx          <= '0;
            exp_idx          <= '0;
            idle_cnt         <= '0;
            o_src_valid      <= 1'b0;
            o_src_data_valid <= 1'b0;
            o_src_data       <= '0;
            o_timeout        <= 1'b0;
            o_err_count      <= '0;
            o_first_err_idx  <= 16'hFFFF;
        end else begin
            state            <= state_next;
            start_q          <= i_start;
            credits          <= credits_n;
            pending          <= pending_n;
            o_src_valid      <= src_valid_n;
            o_src_data_valid <= src_dv_n;
            o_src_data       <= src_data_n;
            if (active) lfsr <= {lfsr[14:0], lfsr_fb};
            if (clear_run) begin
                src_idx         <= '0;
                exp_idx         <= '0;
                idle_cnt        <= '0;
                o_timeout       <= 1'b0;
                o_err_count     <= '0;
                o_first_err_idx <= 16'hFFFF;
            end else begin
                src_idx <= src_idx_n;
                if (chk) begin
                    exp_idx  <= exp_idx + 32'd1;
                    idle_cnt <= '0;
                    if (mism) begin
                        if (o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
                        if (o_first_err_idx == 16'hFFFF) o_first_err_idx <= exp_idx[15:0];
                    end
                end else if (active) begin
                    idle_cnt <= idle_cnt + 32'd1;
                end
                if (to_timeout) o_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_li_traffic_checker.sv
// Bench for li_traffic_checker: credit instance with a FIFO model DUT, qsys and carloni
// instances with pass-through DUTs (qsys one corrupts beat 37).
module tb_li_traffic_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    // credit instance
    logic        c_start, c_src_dv, c_src_valid, c_src_fb, c_snk_dv, c_snk_valid, c_snk_fb;
    logic        c_busy, c_done, c_pass, c_timeout;
    logic [15:0] c_src_data, c_snk_data, c_err, c_first;
    // qsys instance
    logic        q_start, q_src_dv, q_src_valid, q_src_fb, q_snk_dv, q_snk_valid, q_snk_fb;
    logic        q_busy, q_done, q_pass, q_timeout;
    logic [15:0] q_src_data, q_snk_data, q_err, q_first;
    // carloni instance
    logic        k_start, k_src_dv, k_src_valid, k_src_fb, k_snk_dv, k_snk_valid, k_snk_fb;
    logic        k_busy, k_done, k_pass, k_timeout;
    logic [15:0] k_src_data, k_snk_data, k_err, k_first;

    logic [15:0] c_exp_q[$];
    logic [15:0] q_exp_q[$];
    logic [15:0] k_exp_q[$];

    li_traffic_checker #(.MODE(0), .FIFO_ADDR(2), .NUM_BEATS(20), .TIMEOUT(100)) u_credit (
        .clock(clk), .reset(rst_n), .i_start(c_start),
        .o_src_data(c_src_data), .o_src_data_valid(c_src_dv), .o_src_valid(c_src_valid),
        .i_src_feedback(c_src_fb), .i_snk_data(c_snk_data), .i_snk_data_valid(c_snk_dv),
        .i_snk_valid(c_snk_valid), .o_snk_feedback(c_snk_fb), .o_busy(c_busy), .o_done(c_done),
        .o_pass(c_pass), .o_timeout(c_timeout), .o_err_count(c_err), .o_first_err_idx(c_first)
    );

    li_traffic_checker #(.MODE(2), .NUM_BEATS(50), .TIMEOUT(200)) u_qsys (
        .clock(clk), .reset(rst_n), .i_start(q_start),
        .o_src_data(q_src_data), .o_src_data_valid(q_src_dv), .o_src_valid(q_src_valid),
        .i_src_feedback(q_src_fb), .i_snk_data(q_snk_data), .i_snk_data_valid(q_snk_dv),
        .i_snk_valid(q_snk_valid), .o_snk_feedback(q_snk_fb), .o_busy(q_busy), .o_done(q_done),
        .o_pass(q_pass), .o_timeout(q_timeout), .o_err_count(q_err), .o_first_err_idx(q_first)
    );

    li_traffic_checker #(.MODE(1), .NUM_BEATS(40), .TIMEOUT(200)) u_carloni (
        .clock(clk), .reset(rst_n), .i_start(k_start),
        .o_src_data(k_src_data), .o_src_data_valid(k_src_dv), .o_src_valid(k_src_valid),
        .i_src_feedback(k_src_fb), .i_snk_data(k_snk_data), .i_snk_data_valid(k_snk_dv),
        .i_snk_valid(k_snk_valid), .o_snk_feedback(k_snk_fb), .o_busy(k_busy), .o_done(k_done),
        .o_pass(k_pass), .o_timeout(k_timeout), .o_err_count(k_err), .o_first_err_idx(k_first)
    );

    // pass-through DUTs
    assign q_snk_valid = q_src_valid;
    assign q_snk_dv    = q_src_dv;
    assign q_snk_data  = q_src_data ^ {15'd0, (q_src_dv && (q_src_data == 16'd37))};
    assign q_src_fb    = q_snk_fb;
    assign k_snk_valid = k_src_valid;
    assign k_snk_dv    = k_src_dv;
    assign k_snk_data  = k_src_data;
    assign k_src_fb    = k_snk_fb;

    // credit DUT model: input FIFO, 1-cycle output register, 4 downstream credits
    logic [16:0] c_fifo[$];
    logic [16:0] c_e;
    int          c_out_cred;
    bit          c_hold = 1'b0;
    bit          c_man  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            c_fifo.delete();
            c_out_cred = 4;
            c_snk_valid <= 1'b0;
            c_snk_dv    <= 1'b0;
            c_snk_data  <= 16'd0;
            c_src_fb    <= 1'b0;
        end else begin
            if (c_snk_fb) c_out_cred++;
            if (c_src_valid) c_fifo.push_back({c_src_dv, c_src_data});
            if (!c_hold && (c_fifo.size() > 0) && (c_out_cred > 0)) begin
                c_e = c_fifo.pop_front();
                c_out_cred--;
                c_snk_valid <= 1'b1;
                c_snk_dv    <= c_e[16];
                c_snk_data  <= c_e[15:0];
                c_src_fb    <= 1'b1;
            end else begin
                c_snk_valid <= 1'b0;
                c_snk_dv    <= 1'b0;
                c_src_fb    <= c_man;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic extra_beat(input string name, input logic [15:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=0x%0h expected=no-beat", name, act);
    endtask

    // scoreboard monitors: every transferred source data beat pops the ramp queue
    always @(negedge clk) begin
        if (rst_n && c_src_valid && c_src_dv) begin
            if (c_exp_q.size() == 0) extra_beat("c_src_data", c_src_data);
            else check("c_src_data", 32'(c_src_data), 32'(c_exp_q.pop_front()));
        end
        if (rst_n && q_src_valid && q_src_dv && q_src_fb) begin
            if (q_exp_q.size() == 0) extra_beat("q_src_data", q_src_data);
            else check("q_src_data", 32'(q_src_data), 32'(q_exp_q.pop_front()));
        end
        if (rst_n && k_src_valid && k_src_dv && !k_src_fb) begin
            if (k_exp_q.size() == 0) extra_beat("k_src_data", k_src_data);
            else check("k_src_data", 32'(k_src_data), 32'(k_exp_q.pop_front()));
        end
    end

    // carloni: a stopped valid beat must reappear unchanged on the next cycle
    logic        k_hold_prev = 1'b0;
    logic [17:0] k_prev;
    always @(negedge clk) begin
        if (k_hold_prev) check("k_stop_stable", 32'({k_src_valid, k_src_dv, k_src_data}), 32'(k_prev));
        k_hold_prev = rst_n && k_busy && k_src_valid && k_src_fb;
        k_prev      = {k_src_valid, k_src_dv, k_src_data};
    end

    function automatic logic done_of(input int which);
        case (which)
            0:       return c_done;
            1:       return q_done;
            default: return k_done;
        endcase
    endfunction

    task automatic start_run(input int which, input int n);
        case (which)
            0: c_exp_q.delete();
            1: q_exp_q.delete();
            default: k_exp_q.delete();
        endcase
        for (int i = 0; i < n; i++) begin
            case (which)
                0: c_exp_q.push_back(16'(i));
                1: q_exp_q.push_back(16'(i));
                default: k_exp_q.push_back(16'(i));
            endcase
        end
        @(posedge clk); #1;
        case (which)
            0: c_start = 1'b1;
            1: q_start = 1'b1;
            default: k_start = 1'b1;
        endcase
        @(posedge clk); #1;
        c_start = 1'b0;
        q_start = 1'b0;
        k_start = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget, input string name);
        int n = 0;
        while (!done_of(which) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 32'(done_of(which)), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int n;
        rst_n   = 1'b0;
        c_start = 1'b0;
        q_start = 1'b0;
        k_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_c_src_valid", 32'(c_src_valid), 0);
        check("rst_c_busy", 32'(c_busy), 0);
        check("rst_c_done", 32'(c_done), 0);
        check("rst_c_err", 32'(c_err), 0);
        check("rst_c_first", 32'(c_first), 32'hFFFF);
        check("rst_q_snk_fb", 32'(q_snk_fb), 0);
        check("rst_k_first", 32'(k_first), 32'hFFFF);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // credit: plain run
        start_run(0, 20);
        wait_done(0, 1000, "c_run1");
        check("c_run1_pass", 32'(c_pass), 1);
        check("c_run1_err", 32'(c_err), 0);
        check("c_run1_first", 32'(c_first), 32'hFFFF);
        check("c_run1_timeout", 32'(c_timeout), 0);
        check("c_run1_left", 32'(c_exp_q.size()), 0);

        // credit: DUT holds credits, then one credit released
        c_hold = 1'b1;
        start_run(0, 20);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (c_src_valid) cnt++;
        end
        check("c_credit_limit", 32'(cnt), 4);
        check("c_credit_valid_low", 32'(c_src_valid), 0);
        @(posedge clk); #1;
        c_man = 1'b1;
        @(posedge clk); #1;
        c_man = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (c_src_valid) cnt++;
        end
        check("c_credit_one_more", 32'(cnt), 1);
        c_hold = 1'b0;
        wait_done(0, 1000, "c_run2");
        check("c_run2_pass", 32'(c_pass), 1);
        check("c_run2_left", 32'(c_exp_q.size()), 0);

        // credit: reset mid-run, then a fresh run
        start_run(0, 20);
        n = 0;
        while (!(c_src_valid && c_src_dv && (c_src_data == 16'd10)) && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        check("c_reach_beat10", 32'(n < 500), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("c_midrst_busy", 32'(c_busy), 0);
        check("c_midrst_valid", 32'(c_src_valid), 0);
        check("c_midrst_dv", 32'(c_src_dv), 0);
        check("c_midrst_done", 32'(c_done), 0);
        check("c_midrst_first", 32'(c_first), 32'hFFFF);
        check("c_midrst_snk_fb", 32'(c_snk_fb), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_run(0, 20);
        wait_done(0, 1000, "c_run3");
        check("c_run3_pass", 32'(c_pass), 1);
        check("c_run3_err", 32'(c_err), 0);
        check("c_run3_left", 32'(c_exp_q.size()), 0);

        // credit: nothing ever returns -> timeout after 100 idle cycles
        c_hold = 1'b1;
        start_run(0, 20);
        repeat (95) @(posedge clk);
        @(negedge clk);
        check("c_tmo_early_done", 32'(c_done), 0);
        wait_done(0, 20, "c_tmo");
        check("c_tmo_flag", 32'(c_timeout), 1);
        check("c_tmo_pass", 32'(c_pass), 0);
        check("c_tmo_busy", 32'(c_busy), 0);

        // qsys: beat 37 corrupted by the DUT
        start_run(1, 50);
        wait_done(1, 3000, "q_run");
        check("q_err", 32'(q_err), 1);
        check("q_first", 32'(q_first), 37);
        check("q_pass", 32'(q_pass), 0);
        check("q_timeout", 32'(q_timeout), 0);
        check("q_left", 32'(q_exp_q.size()), 0);

        // carloni: random bubbles and stops
        start_run(2, 40);
        wait_done(2, 3000, "k_run");
        check("k_pass", 32'(k_pass), 1);
        check("k_err", 32'(k_err), 0);
        check("k_first", 32'(k_first), 32'hFFFF);
        check("k_left", 32'(k_exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
